// File: rtl/demux_rr_scheduler_if.sv
// Handshake bundle between the word source, the scheduler and the four demux channels.
interface demux_rr_scheduler_if #(parameter int DW = 8);
  logic [3:0]    ch_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    out_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic          a;
  logic          b;
  logic          drop;
  logic [7:0]    drop_cnt;

  modport master (
    output ch_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, a, b, drop, drop_cnt
  );

  modport slave (
    input  ch_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, a, b, drop, drop_cnt
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin 1-to-4 demux sequencer: one-entry holding stage drives the select lines,
// bursts of BURST words per channel, stalled words are dropped after TIMEOUT cycles.
module demux_rr_scheduler #(
  parameter int DW      = 8,
  parameter int BURST   = 2,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_rr_scheduler_if.slave   bus
);
  localparam int NCH = 4;
  localparam int BW  = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    hold_sel;
  logic [DW-1:0] hold_data;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] stall_cnt;
  logic [7:0]    drop_cnt_q;

  logic [1:0]    target;
  logic [1:0]    cand;
  logic          found;
  logic          full, fire, tmo, in_ready_w, accept;

  // First enabled channel at or after ptr, wrapping.
  always_comb begin
    target = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int k = 0; k < NCH; k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.ch_en[cand]) begin
        target = cand;
        found  = 1'b1;
      end
    end
  end

  assign full       = (state == FULL);
  assign fire       = full & bus.out_ready[hold_sel];
  assign tmo        = full & ~fire & (stall_cnt == CW'(TIMEOUT - 1));
  assign in_ready_w = rst_n & (bus.ch_en != 4'b0) & (~full | fire | tmo);
  assign accept     = bus.in_valid & in_ready_w;

  assign bus.in_ready = in_ready_w;
  assign bus.drop     = rst_n & tmo;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.out_data = hold_data;
  assign bus.a        = hold_sel[1];
  assign bus.b        = hold_sel[0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign bus.out_valid[i] = full & (hold_sel == 2'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      hold_sel   <= '0;
      hold_data  <= '0;
      burst_cnt  <= '0;
      stall_cnt  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept) begin
        hold_data <= bus.in_data;
        hold_sel  <= target;
        state     <= FULL;
        stall_cnt <= '0;
        // Skipping a disabled pointer restarts the burst on the channel actually used.
        if (target != ptr) begin
          if (BURST == 1) begin
            ptr       <= target + 2'd1;
            burst_cnt <= '0;
          end else begin
            ptr       <= target;
            burst_cnt <= BW'(1);
          end
        end else if (burst_cnt == BW'(BURST - 1)) begin
          ptr       <= target + 2'd1;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end else if (fire | tmo) begin
        state     <= EMPTY;
        stall_cnt <= '0;
      end else if (full) begin
        stall_cnt <= stall_cnt + CW'(1);
      end

      if (tmo && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench: driver pushes expected words at accept, negedge monitor checks outputs.
module tb_demux_rr_scheduler;
  localparam int DW = 8, BURST = 2, TIMEOUT = 16, CW = 5;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_rr_scheduler_if #(.DW(DW)) bus ();

  demux_rr_scheduler #(.DW(DW), .BURST(BURST), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_ptr = 0, m_run = 0;
  int   exp_drops = 0;
  int   age = 0;
  logic [1:0]    last_sel = '0;
  logic [DW-1:0] last_data = '0;
  bit   m_held, m_fire, m_tmo;
  logic [3:0] m_ov;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference channel choice: scan from the pointer for the first enabled channel.
  function automatic int pick(int p, logic [3:0] en);
    for (int k = 0; k < 4; k++)
      if (en[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One clock: decide acceptance just before the edge, then re-drive after it.
  task automatic step(output bit acc);
    int t;
    @(negedge clk); #2;
    acc = 1'b0;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      acc = 1'b1;
      t = pick(m_ptr, bus.ch_en);
      chk("accept_has_channel", (t >= 0), 1);
      if (t >= 0) begin
        q.push_back('{ch: 2'(t), data: bus.in_data});
        if (t != m_ptr) begin m_ptr = t; m_run = 0; end
        m_run++;
        if (m_run == BURST) begin m_ptr = (t + 1) % 4; m_run = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cycles(int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  task automatic send(logic [DW-1:0] d);
    bit acc = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) step(acc);
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic do_reset();
    bit acc;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step(acc);
    rst_n = 1'b1;
    m_ptr = 0;
    m_run = 0;
  endtask

  // Monitor: compare presented outputs against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", bus.in_ready, 0);
      chk("drop_in_reset", bus.drop, 0);
      q.delete();
      age = 0; exp_drops = 0; last_sel = '0; last_data = '0;
    end else begin
      m_held = (q.size() > 0);
      m_fire = m_held && bus.out_ready[q[0].ch];
      m_tmo  = m_held && !m_fire && (age == TIMEOUT - 1);
      if (m_held) begin
        m_ov = 4'b0001 << q[0].ch;
        chk("out_data", bus.out_data, q[0].data);
        chk("sel_ab", {bus.a, bus.b}, q[0].ch);
        last_sel = q[0].ch;
        last_data = q[0].data;
      end else begin
        m_ov = 4'b0000;
        chk("out_data_hold", bus.out_data, last_data);
        chk("sel_ab_hold", {bus.a, bus.b}, last_sel);
      end
      chk("out_valid", bus.out_valid, m_ov);
      chk("drop", bus.drop, m_tmo);
      chk("in_ready", bus.in_ready, (bus.ch_en != 4'b0) && (!m_held || m_fire || m_tmo));
      chk("drop_cnt", bus.drop_cnt, exp_drops);
      if (m_fire || m_tmo) begin
        void'(q.pop_front());
        age = 0;
        if (m_tmo && exp_drops < 255) exp_drops++;
      end else if (m_held) begin
        age++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_en = 4'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 4'b0;
    @(posedge clk); #1;
    do_reset();
    cycles(2);

    // Round-robin bursts at full rate.
    bus.ch_en = 4'b1111; bus.out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    bus.in_valid = 1'b0;
    cycles(2);

    // Disabled channels are skipped.
    bus.ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    bus.in_valid = 1'b0;
    cycles(2);

    // Backpressure on A, then release.
    bus.ch_en = 4'b0001; bus.out_ready = 4'b1110;
    send(8'h30);
    bus.in_data = 8'h31;
    cycles(5);
    bus.out_ready = 4'b1111;
    cycles(3);
    bus.in_valid = 1'b0;
    cycles(2);

    // Timeouts on C until the drop counter saturates.
    bus.ch_en = 4'b0100; bus.out_ready = 4'b0000; bus.in_valid = 1'b1;
    for (int i = 0; i < 300 * TIMEOUT + 40; i++) begin
      bus.in_data = 8'($urandom);
      cycles(1);
    end
    bus.in_valid = 1'b0;
    chk("drop_cnt_saturated", bus.drop_cnt, 255);
    cycles(TIMEOUT + 2);

    // Reset while holding a word on B mid-burst.
    do_reset();
    bus.ch_en = 4'b1111; bus.out_ready = 4'b1111;
    send(8'h40); send(8'h41);
    bus.out_ready = 4'b0000;
    send(8'h42);
    bus.in_valid = 1'b0;
    cycles(3);
    do_reset();
    chk("drop_cnt_after_reset", bus.drop_cnt, 0);
    bus.out_ready = 4'b1111;
    send(8'h43);
    bus.in_valid = 1'b0;
    cycles(2);

    // No channel enabled: nothing accepted; re-enable C.
    bus.ch_en = 4'b0000; bus.in_valid = 1'b1; bus.in_data = 8'h50;
    cycles(4);
    bus.ch_en = 4'b0100;
    send(8'h51);
    bus.in_valid = 1'b0;
    cycles(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = (i % 600 < 300) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) bus.ch_en = 4'($urandom);
      cycles(1);
    end

    // Drain.
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111; bus.ch_en = 4'b1111;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycles(1);
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Sequences the 1-to-4 demultiplexer: takes a valid/ready input word stream and steers each word to one of four output channels (A..D).
- Channels are served round-robin with a configurable burst length and a per-channel enable mask.
- Drives the demux select lines (`a` = MSB, `b` = LSB) from a registered one-entry holding stage.
- A stall timeout drops words that a channel never takes.

Parameters:
- `DW`, 8, data word width.
- `BURST`, 2, words sent to one channel before the pointer advances (≥1).
- `TIMEOUT`, 16, cycles a held word may wait for its channel's ready before it is dropped (≥2).
- `CW`, 5, width of the stall counter; must satisfy 2^CW > TIMEOUT.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `ch_en`  in  4  channel enable mask, bit i = channel i (0=A, 1=B, 2=C, 3=D).
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid & in_ready`.
- `in_data`  in  DW  input word.
- `out_ready`  in  4  per-channel ready.
- `out_valid`  out  4  one-hot valid for the held word's channel.
- `out_data`  out  DW  held word (broadcast to all channels).
- `a`  out  1  demux select MSB (= `hold_sel[1]`).
- `b`  out  1  demux select LSB (= `hold_sel[0]`).
- `drop`  out  1  one-cycle pulse when a held word times out.
- `drop_cnt`  out  8  saturating count of dropped words.

Behaviour:
- Reset (`rst_n` = 0 at a clock edge) forces:
  - `ptr`=0, `burst_cnt`=0, `stall_cnt`=0, FSM=EMPTY;
  - `out_valid`=0, `out_data`=0, `a`=`b`=0, `drop`=0, `drop_cnt`=0, `in_ready`=0 that cycle.
  - A word held at reset is discarded and not counted.
- FSM states:
  - EMPTY: nothing held.
  - FULL: one word held in `hold_data`/`hold_sel`.
- Handshake definitions:
  - `fire` = FULL & `out_ready[hold_sel]`.
  - `tmo` = FULL & ~`fire` & (`stall_cnt` == TIMEOUT-1).
  - `in_ready` = (`ch_en` != 0) & (EMPTY | `fire` | `tmo`).
  - `in_ready` is combinational from state, `ch_en` and `out_ready`; it never depends on `in_valid`.
- Channel choice at accept:
  - `target` = first i in order `ptr`, `ptr`+1, ... (mod 4) with `ch_en[i]`=1.
  - If `ch_en` = 0, no accept occurs.
- On accept (`in_valid & in_ready`):
  - `hold_data` <= `in_data`, `hold_sel` <= `target`, FSM <= FULL, `stall_cnt` <= 0.
  - If `target` != `ptr`: `burst_cnt` <= 1, or if BURST == 1, advance immediately (`ptr` <= `target`+1, `burst_cnt` <= 0).
  - Else if `burst_cnt` == BURST-1: `ptr` <= `target`+1 (mod 4), `burst_cnt` <= 0.
  - Else `burst_cnt` <= `burst_cnt`+1.
  - Skipping a disabled pointer therefore restarts the burst on the new channel.
- `fire` without accept: FSM <= EMPTY.
- Simultaneous `fire` and accept: the new word replaces the old one in the same edge, so a full rate of one word per cycle is sustained.
- Stall timing:
  - While FULL & ~`fire`: `stall_cnt` increments.
  - On `tmo`: `drop` = 1 for one cycle, `drop_cnt` += 1 (saturates at 255), and the held word is discarded (FSM <= EMPTY unless an accept happens the same edge).
- Outputs:
  - `out_valid[i]` = FULL & (`hold_sel` == i), registered-state driven.
  - `out_data`, `a`, `b` hold their last value while EMPTY.
- Latency: input accepted at edge N appears on `out_valid`/`a`/`b` after edge N (one cycle).
- `ch_en` changes mid-operation:
  - They affect only future target selection.
  - A word already held waits on its original channel even if that channel is disabled; it is released only by `fire` or `tmo`.
- `ch_en` = 0 while FULL: `in_ready` = 0; the held word still drains or times out.
- `ptr` wraps from 3 to 0.

Test Plan:
- Round-robin burst: `ch_en`=4'b1111, BURST=2, `out_ready`=4'b1111, 8 back-to-back words 0x10..0x17 → channels A,A,B,B,C,C,D,D; (`a`,`b`) = 00,00,01,01,10,10,11,11; `in_ready` stays 1; no `drop`.
- Disabled channels: `ch_en`=4'b1010, BURST=1, 4 words → channels B,D,B,D; `ptr` skips A and C.
- Backpressure: `out_ready[0]`=0 for 5 cycles with a word held on A → `out_valid`=4'b0001 steady, `in_ready`=0; `out_ready[0]`=1 → `fire` and `in_ready`=1 the same cycle.
- Timeout: TIMEOUT=16, `out_ready`=0 with a word held on C → `drop` pulses exactly 16 cycles after accept, `drop_cnt`=1, `out_valid`=0 next cycle; repeat 300 times → `drop_cnt` saturates at 255.
- Reset mid-burst: FULL on B with `burst_cnt`=1, assert `rst_n`=0 for 1 cycle → `out_valid`=0, `a`=`b`=0, `drop_cnt`=0; next word goes to A.
- `ch_en`=0 → `in_ready`=0 regardless of `in_valid`; restore 4'b0100 → next word goes to C.
